// File: rtl/addsub_serial_pkg.sv
// Shared encodings for the digit-serial adder/subtractor: FSM states and mode values.
package addsub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_digit.sv
// DIGIT-wide combinational ripple slice; c_msb is the carry entering the slice MSB.
module addsub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] carry_s;

    // Bit-by-bit ripple through the slice
    always_comb begin
        carry_s    = '0;
        sum        = '0;
        carry_s[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = x[i] ^ y[i] ^ carry_s[i];
            carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
        end
    end

    assign cout  = carry_s[DIGIT];
    assign c_msb = carry_s[DIGIT-1];

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial A+B / A-B: one DIGIT-wide slice per cycle, LSB first, result held until taken.
module addsub_serial
    import addsub_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t             state_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [WIDTH-1:0]   acc_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   s_r;
    logic               cout_r;
    logic               ovf_r;
    logic               zero_r;
    logic               in_ready_r;
    logic               out_valid_r;

    logic [DIGIT-1:0]   dig_sum_s;
    logic               dig_cout_s;
    logic               dig_cmsb_s;
    logic [WIDTH-1:0]   acc_next_s;
    logic               last_s;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .x     (a_r[DIGIT-1:0]),
        .y     (b_r[DIGIT-1:0]),
        .cin   (carry_r),
        .sum   (dig_sum_s),
        .cout  (dig_cout_s),
        .c_msb (dig_cmsb_s)
    );

    // Result shift register enters from the top so the LSB slice ends up at bit 0
    always_comb begin
        acc_next_s                     = acc_r >> DIGIT;
        acc_next_s[WIDTH-1 -: DIGIT]   = dig_sum_s;
        last_s                         = (idx_r == IDX_W'(NDIG - 1));
    end

    // Control FSM with datapath and registered handshake/result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            carry_r     <= 1'b0;
            idx_r       <= '0;
            s_r         <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b ^ {WIDTH{m}};
                        carry_r    <= (m == MODE_SUB);
                        idx_r      <= '0;
                        acc_r      <= '0;
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> DIGIT;
                    b_r     <= b_r >> DIGIT;
                    carry_r <= dig_cout_s;
                    acc_r   <= acc_next_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        s_r         <= acc_next_s;
                        cout_r      <= dig_cout_s;
                        ovf_r       <= dig_cout_s ^ dig_cmsb_s;
                        zero_r      <= (acc_next_s == '0);
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench: three instances (DIGIT = 4, 1, 16) driven in lockstep with shared stimulus.
module tb_addsub_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        m = 1'b0;

    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  cout_v;
    logic [2:0]  ovf_v;
    logic [2:0]  zero_v;
    logic [15:0] s_v [3];

    int vectors = 0;
    int fails   = 0;
    int lat_exp [3] = '{4, 16, 1};

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .m(m), .out_valid(out_valid_v[0]), .out_ready(out_ready),
        .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]), .zero(zero_v[0]));

    addsub_serial #(.WIDTH(16), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .m(m), .out_valid(out_valid_v[1]), .out_ready(out_ready),
        .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]), .zero(zero_v[1]));

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .m(m), .out_valid(out_valid_v[2]), .out_ready(out_ready),
        .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]), .zero(zero_v[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accept one op in all instances, scramble inputs, measure latency, check result, release.
    task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic mv, input logic [15:0] es, input logic ec,
                          input logic eo, input logic ez);
        int lat [3];
        lat = '{0, 0, 0};
        @(negedge clk);
        chk({tag, " ready"}, {29'd0, in_ready_v}, 32'h7);
        a = av; b = bv; m = mv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~av; b = ~bv; m = ~mv;
        chk({tag, " busy"}, {26'd0, in_ready_v, out_valid_v}, 32'h0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (out_valid_v[i] && lat[i] == 0) lat[i] = k;
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s d%0d lat", tag, i), lat[i], lat_exp[i]);
            chk($sformatf("%s d%0d s", tag, i), {16'd0, s_v[i]}, {16'd0, es});
            chk($sformatf("%s d%0d flags", tag, i),
                {29'd0, cout_v[i], ovf_v[i], zero_v[i]}, {29'd0, ec, eo, ez});
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, " released"}, {26'd0, in_ready_v, out_valid_v}, 32'h38);
    endtask

    initial begin
        int seen;
        #12;
        chk("rst in_ready", {29'd0, in_ready_v}, 32'h7);
        chk("rst out_valid", {29'd0, out_valid_v}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst d%0d s", i), {16'd0, s_v[i]}, 32'h0);
            chk($sformatf("rst d%0d flags", i), {29'd0, cout_v[i], ovf_v[i], zero_v[i]}, 32'h0);
        end
        @(negedge clk); rst_n = 1'b1;

        run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero",  16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);

        // Backpressure: result held while new operands wait
        @(negedge clk); a = 16'h1111; b = 16'h2222; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); a = 16'h0001; b = 16'h0001; m = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d hs", k), {26'd0, in_ready_v, out_valid_v}, 32'h7);
            for (int i = 0; i < 3; i++)
                chk($sformatf("hold%0d d%0d s", k, i), {16'd0, s_v[i]}, 32'h3333);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("hold to_idle", {26'd0, in_ready_v, out_valid_v}, 32'h38);
        @(posedge clk); #1; in_valid = 1'b0;
        chk("hold accepted", {29'd0, in_ready_v}, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("hold new d%0d s", i), {16'd0, s_v[i]}, 32'h0002);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // Reset mid-operation (DIGIT=4 instance at index 2)
        @(negedge clk); a = 16'h1234; b = 16'h4321; m = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("abort hs", {26'd0, in_ready_v, out_valid_v}, 32'h38);
        for (int i = 0; i < 3; i++)
            chk($sformatf("abort d%0d s", i), {16'd0, s_v[i]}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid_v != 3'b000) seen++;
        end
        chk("no stale result", seen, 32'd0);
        chk("no stale s", {16'd0, s_v[0]}, 32'h0);

        run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per clock cycle; WIDTH % DIGIT == 0 and DIGIT >= 1 are required; NDIG = WIDTH/DIGIT.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands and mode are presented.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port m  input  1  mode: 0 = A+B, 1 = A-B (A + ~B + 1).
REQ-010 SHALL have port out_valid  output  1  result and flags are valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port s  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of the MSB (for subtraction 1 = no borrow).
REQ-014 SHALL have port ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
REQ-015 SHALL have port zero  output  1  s == 0.

Function
REQ-016 SHALL implement a three-state machine IDLE, RUN, DONE.
REQ-017 In IDLE: in_ready = 1 and out_valid = 0; on in_valid && in_ready, SHALL latch a, b XOR {WIDTH{m}}, and carry-in = m; SHALL clear the digit index; SHALL enter RUN.
REQ-018 In RUN: SHALL add one DIGIT-wide slice per cycle, LSB slice first, propagating the registered carry; SHALL increment the index; SHALL enter DONE after the slice at index NDIG-1.
REQ-019 Latency: out_valid SHALL rise exactly NDIG cycles after the accepting edge (DIGIT == WIDTH gives 1 cycle).
REQ-020 In DONE: out_valid = 1; s, cout, ovf and zero SHALL stay stable until out_valid && out_ready, which SHALL return the machine to IDLE.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid, a, b and m SHALL be ignored there (no accept in the DONE->IDLE cycle; max throughput is one op per NDIG+2 cycles).
REQ-022 s, cout, ovf and zero SHALL update only on entry to DONE and SHALL hold their last values otherwise.
REQ-023 Changes to a, b or m after acceptance SHALL NOT affect the result in flight.
REQ-024 ovf SHALL use the carry into bit WIDTH-1; for DIGIT == 1 this is the stored carry before the final slice.

Reset
REQ-025 While rst_n = 0: state SHALL be IDLE; in_ready = 1; out_valid = 0; s = 0; cout = ovf = 0; zero = 0; internal operands, carry and index SHALL be 0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation immediately; no result SHALL be presented after release.
REQ-027 The first accept SHALL be possible on the first rising edge with rst_n = 1.

Structure
REQ-028 A shared package/header SHALL hold the state encodings (IDLE = 0, RUN = 1, DONE = 2) and the mode constants ADD = 0, SUB = 1.
REQ-029 SHALL instantiate one sub-module, addsub_digit (DIGIT-wide ripple slice: inputs x, y, cin; outputs sum, cout, c_msb = carry into its MSB); it SHALL be combinational and SHALL be the only adder in the block.
REQ-030 Operand registers SHALL shift right by DIGIT per RUN cycle; the result SHALL assemble in a shift register copied to s on DONE entry.

Verification (WIDTH = 16, DIGIT = 4 unless stated)
REQ-031 a = 0x1234, b = 0x4321, m = 0 -> s = 0x5555, cout = 0, ovf = 0, zero = 0; out_valid exactly 4 cycles after accept.
REQ-032 a = 0x0005, b = 0x0007, m = 1 -> s = 0xFFFE, cout = 0, ovf = 0; then a = 0xABCD, b = 0xABCD, m = 1 -> s = 0x0000, zero = 1, cout = 1.
REQ-033 a = 0x7FFF, b = 0x0001, m = 0 -> s = 0x8000, ovf = 1, cout = 0; then a = 0x8000, b = 0x0001, m = 1 -> s = 0x7FFF, ovf = 1, cout = 1.
REQ-034 Hold out_ready = 0 for 3 cycles in DONE while driving in_valid = 1 with new operands -> out_valid, s and flags stay stable; in_ready = 0; the new operands are not accepted until the cycle after IDLE is re-entered.
REQ-035 Pulse rst_n low for 1 cycle at RUN index 2 -> out_valid = 0 and s = 0 immediately; in_ready = 1; no stale result appears afterwards.
REQ-036 Repeat REQ-031..033 with DIGIT = 1 (latency 16) and DIGIT = 16 (latency 1) -> identical results and flags.
